// File: rtl/input_buffer_pkg.sv
// Shared constants for the router input buffer: default flit width, FIFO depth
// and the packet FSM state encodings.
package input_buffer_pkg;
  localparam int TAM_FLIT     = 16;
  localparam int BUFFER_DEPTH = 4;

  localparam logic [2:0] IB_IDLE     = 3'd0;
  localparam logic [2:0] IB_HEADER   = 3'd1;
  localparam logic [2:0] IB_SEND_HDR = 3'd2;
  localparam logic [2:0] IB_SIZE     = 3'd3;
  localparam logic [2:0] IB_PAYLOAD  = 3'd4;
  localparam logic [2:0] IB_END      = 3'd5;
endpackage

// File: rtl/input_buffer_flit_fifo.sv
// Circular flit RAM with wrapping pointers, occupancy count, registered credit
// and a sticky overflow flag for pushes attempted while full.
module flit_fifo
  import input_buffer_pkg::*;
#(
  parameter int WIDTH = TAM_FLIT,
  parameter int DEPTH = BUFFER_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             rx,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             credit,
  output logic             ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             full, push;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = rx & ~full;
  assign dout  = ram[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (pop && !push) count_nxt = count - CNT_ONE;
  end

  // Credit looks at the post-edge count so it already reflects this cycle's push/pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      credit <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count  <= count_nxt;
      credit <= (count_nxt != FULL_CNT);
      if (rx && full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) ram[wr_ptr] <= din;
  end
endmodule

// File: rtl/input_buffer.sv
// NoC router input port: buffers flits, raises a routing request per packet
// header, then streams header, size and payload flits to the crossbar.
module input_buffer #(
  parameter int TAM_FLIT = input_buffer_pkg::TAM_FLIT,
  parameter int DEPTH    = input_buffer_pkg::BUFFER_DEPTH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rx,
  input  logic [TAM_FLIT-1:0] i_data_in,
  output logic                o_credit,
  output logic                o_h,
  input  logic                i_ack_h,
  output logic                o_data_av,
  output logic [TAM_FLIT-1:0] o_data,
  input  logic                i_data_ack,
  output logic                o_sender,
  output logic                o_ovf
);
  import input_buffer_pkg::*;

  localparam logic [TAM_FLIT-1:0] FLIT_ONE = TAM_FLIT'(1);

  logic [2:0]          state, state_nxt;
  logic [TAM_FLIT-1:0] pay_cnt;
  logic                empty, pop;

  flit_fifo #(.WIDTH(TAM_FLIT), .DEPTH(DEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .rx     (i_rx),
    .din    (i_data_in),
    .pop    (pop),
    .dout   (o_data),
    .empty  (empty),
    .credit (o_credit),
    .ovf    (o_ovf)
  );

  // Sender is decoded from the streaming states so a reset drops it on the next cycle.
  assign o_h       = (state == IB_HEADER);
  assign o_sender  = (state == IB_SEND_HDR) || (state == IB_SIZE) || (state == IB_PAYLOAD);
  assign o_data_av = o_sender & ~empty;
  assign pop       = o_data_av & i_data_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      IB_IDLE:     if (!empty) state_nxt = IB_HEADER;
      IB_HEADER:   if (i_ack_h) state_nxt = IB_SEND_HDR;
      IB_SEND_HDR: if (pop) state_nxt = IB_SIZE;
      IB_SIZE:     if (pop) state_nxt = (o_data == '0) ? IB_END : IB_PAYLOAD;
      IB_PAYLOAD:  if (pop && pay_cnt == FLIT_ONE) state_nxt = IB_END;
      IB_END:      state_nxt = IB_IDLE;
      default:     state_nxt = IB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IB_IDLE;
      pay_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop && state == IB_SIZE)         pay_cnt <= o_data;
      else if (pop && state == IB_PAYLOAD) pay_cnt <= pay_cnt - FLIT_ONE;
    end
  end
endmodule
